// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM pipeline decode/execute boundary.
package arm_pipe_pkg;

  localparam logic [3:0] R15 = 4'hF;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       branch;
    logic       alusrc;
    logic [1:0] alucontrol;
    logic [1:0] flagwrite;
    logic [3:0] cond;
  } ctrl_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_W  = 2'd1,
    FWD_M  = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode, M/W writeback and E-stage signals crossing the id_ex_stage boundary.
interface id_ex_stage_if
  import arm_pipe_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned CNTW = 16
);
  logic          valid_d;
  logic [3:0]    ra1_d, ra2_d, wa3_d;
  logic [DW-1:0] rd1_d, rd2_d, extimm_d;
  ctrl_t         ctrl_d;

  logic [DW-1:0] aluresult_m, result_w;
  logic [3:0]    wa3_m, wa3_w;
  logic          regwrite_m, valid_m, regwrite_w, valid_w;

  logic          branch_take, hold;

  logic          valid_e;
  logic [DW-1:0] srca_e, writedata_e, extimm_e;
  logic [3:0]    wa3_e, ra1_e, ra2_e;
  ctrl_t         ctrl_e;

  logic          stall_f, stall_d, flush_d;
  logic [CNTW-1:0] stall_cnt, bubble_cnt;

  modport master (
    output valid_d, ra1_d, ra2_d, wa3_d, rd1_d, rd2_d, extimm_d, ctrl_d,
    output aluresult_m, result_w, wa3_m, wa3_w, regwrite_m, valid_m, regwrite_w, valid_w,
    output branch_take, hold,
    input  valid_e, srca_e, writedata_e, extimm_e, wa3_e, ra1_e, ra2_e, ctrl_e,
    input  stall_f, stall_d, flush_d, stall_cnt, bubble_cnt
  );

  modport slave (
    input  valid_d, ra1_d, ra2_d, wa3_d, rd1_d, rd2_d, extimm_d, ctrl_d,
    input  aluresult_m, result_w, wa3_m, wa3_w, regwrite_m, valid_m, regwrite_w, valid_w,
    input  branch_take, hold,
    output valid_e, srca_e, writedata_e, extimm_e, wa3_e, ra1_e, ra2_e, ctrl_e,
    output stall_f, stall_d, flush_d, stall_cnt, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage_fwd_select.sv
// Per-operand forwarding source choice; M beats W, r15 is never forwarded.
module fwd_select
  import arm_pipe_pkg::*;
(
  input  logic [3:0] ra_e,
  input  logic [3:0] wa3_m,
  input  logic       wr_m,
  input  logic [3:0] wa3_w,
  input  logic       wr_w,
  output fwd_sel_t   sel_c
);

  always_comb begin
    sel_c = FWD_RF;
    if (ra_e != R15) begin
      if (wr_m && (wa3_m == ra_e))      sel_c = FWD_M;
      else if (wr_w && (wa3_w == ra_e)) sel_c = FWD_W;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register with M/W forwarding, load-use stall,
// branch flush (deferred across hold) and saturating stall/bubble counters.
module id_ex_stage
  import arm_pipe_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned CNTW = 16
)
(
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);

  logic            valid_q, flush_pend;
  ctrl_t           ctrl_q;
  logic [DW-1:0]   rd1_q, rd2_q, extimm_q;
  logic [3:0]      wa3_q, ra1_q, ra2_q;
  logic [CNTW-1:0] stall_cnt_q, bubble_cnt_q;

  logic     ldstall_c, bubble_c, stall_c, flush_c, count_stall_c;
  logic     wr_m_c, wr_w_c;
  fwd_sel_t sel_a_c, sel_b_c;

  // Load-use hazard against the instruction currently in E.
  always_comb begin
    ldstall_c = valid_q && ctrl_q.memtoreg && bus.valid_d &&
                (((bus.ra1_d == wa3_q) && (bus.ra1_d != R15)) ||
                 ((bus.ra2_d == wa3_q) && (bus.ra2_d != R15)));
    stall_c       = ldstall_c || bus.hold;
    flush_c       = bus.branch_take && !bus.hold;
    bubble_c      = !bus.hold && (bus.branch_take || flush_pend || ldstall_c);
    // A squashed decode slot is not counted as a stall.
    count_stall_c = stall_c && !flush_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      flush_pend <= 1'b0;
      ctrl_q     <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      extimm_q   <= '0;
      wa3_q      <= '0;
      ra1_q      <= '0;
      ra2_q      <= '0;
    end else if (bus.hold) begin
      if (bus.branch_take) flush_pend <= 1'b1;
    end else if (bubble_c) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      flush_pend <= 1'b0;
    end else begin
      valid_q  <= bus.valid_d;
      ctrl_q   <= bus.ctrl_d;
      rd1_q    <= bus.rd1_d;
      rd2_q    <= bus.rd2_d;
      extimm_q <= bus.extimm_d;
      wa3_q    <= bus.wa3_d;
      ra1_q    <= bus.ra1_d;
      ra2_q    <= bus.ra2_d;
    end
  end

  // Performance counters stick at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (count_stall_c && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNTW'(1);
      if (bubble_c && (bubble_cnt_q != '1))
        bubble_cnt_q <= bubble_cnt_q + CNTW'(1);
    end
  end

  assign wr_m_c = bus.valid_m && bus.regwrite_m;
  assign wr_w_c = bus.valid_w && bus.regwrite_w;

  fwd_select u_fwd_a (
    .ra_e (ra1_q), .wa3_m(bus.wa3_m), .wr_m(wr_m_c),
    .wa3_w(bus.wa3_w), .wr_w(wr_w_c), .sel_c(sel_a_c)
  );

  fwd_select u_fwd_b (
    .ra_e (ra2_q), .wa3_m(bus.wa3_m), .wr_m(wr_m_c),
    .wa3_w(bus.wa3_w), .wr_w(wr_w_c), .sel_c(sel_b_c)
  );

  always_comb begin
    bus.srca_e = rd1_q;
    case (sel_a_c)
      FWD_M:   bus.srca_e = bus.aluresult_m;
      FWD_W:   bus.srca_e = bus.result_w;
      default: bus.srca_e = rd1_q;
    endcase
  end

  always_comb begin
    bus.writedata_e = rd2_q;
    case (sel_b_c)
      FWD_M:   bus.writedata_e = bus.aluresult_m;
      FWD_W:   bus.writedata_e = bus.result_w;
      default: bus.writedata_e = rd2_q;
    endcase
  end

  assign bus.valid_e    = valid_q;
  assign bus.ctrl_e     = ctrl_q;
  assign bus.extimm_e   = extimm_q;
  assign bus.wa3_e      = wa3_q;
  assign bus.ra1_e      = ra1_q;
  assign bus.ra2_e      = ra2_q;
  assign bus.stall_f    = stall_c;
  assign bus.stall_d    = stall_c;
  assign bus.flush_d    = flush_c;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;

endmodule
